// File: rtl/decoder_xx6812.sv
// One-wire WS2812/SK6812 stream decoder: recovers pixel words, LED index and frame gaps.
// Optional DECODER_FORWARD_EN adds serial_data_out, forwarding the line after the first word.
module decoder_xx6812 #(
    parameter int WORD_BITS        = 24,
    parameter int THRESHOLD_CYCLES = 7,
    parameter int MIN_HIGH_CYCLES  = 2,
    parameter int RESET_CYCLES     = 960
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 serial_data_in,
    output logic [WORD_BITS-1:0] parallel_data_out,
    output logic                 data_ready,
    output logic [8:0]           led_index,
    output logic                 frame_done,
    output logic                 bit_error
`ifdef DECODER_FORWARD_EN
    ,
    output logic                 serial_data_out
`endif
);

    localparam int CNT_W = $clog2(RESET_CYCLES + 1);
    localparam int BC_W  = $clog2(WORD_BITS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_THR   = CNT_W'(THRESHOLD_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MIN   = CNT_W'(MIN_HIGH_CYCLES);
    localparam logic [BC_W-1:0]  BIT_LAST  = BC_W'(WORD_BITS - 1);

    typedef enum logic [1:0] {SYNC, IDLE, HIGH, LOW} state_t;

    state_t               state, state_nxt;
    logic                 sync_p0, sync_p1;
    logic [CNT_W-1:0]     cnt, cnt_nxt;
    logic [BC_W-1:0]      bit_cnt, bit_cnt_nxt;
    logic [WORD_BITS-1:0] shreg, shreg_nxt, new_word;
    logic [WORD_BITS-1:0] data_nxt;
    logic [8:0]           word_cnt, word_cnt_nxt, index_nxt;
    logic                 ready_nxt, done_nxt, err_nxt, clear_frame, bit_val;

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        bit_cnt_nxt  = bit_cnt;
        shreg_nxt    = shreg;
        data_nxt     = parallel_data_out;
        word_cnt_nxt = word_cnt;
        index_nxt    = led_index;
        ready_nxt    = 1'b0;
        done_nxt     = 1'b0;
        err_nxt      = 1'b0;
        clear_frame  = 1'b0;
        bit_val      = (cnt >= CNT_THR);
        new_word     = {shreg[WORD_BITS-2:0], bit_val};

        case (state)
            SYNC: begin
                if (sync_p1) begin
                    cnt_nxt = '0;
                end else if (cnt == CNT_LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            IDLE: begin
                bit_cnt_nxt = '0;
                if (sync_p1) begin
                    cnt_nxt   = CNT_ONE;
                    state_nxt = HIGH;
                end
            end
            HIGH: begin
                // Stuck-high and runt pulses both abandon the frame and resynchronise.
                if ((sync_p1 && cnt == CNT_LAST) || (!sync_p1 && cnt < CNT_MIN)) begin
                    err_nxt      = 1'b1;
                    clear_frame  = 1'b1;
                    cnt_nxt      = '0;
                    bit_cnt_nxt  = '0;
                    word_cnt_nxt = '0;
                    state_nxt    = SYNC;
                end else if (sync_p1) begin
                    cnt_nxt = cnt + CNT_ONE;
                end else begin
                    shreg_nxt = new_word;
                    cnt_nxt   = CNT_ONE;
                    state_nxt = LOW;
                    if (bit_cnt == BIT_LAST) begin
                        data_nxt     = new_word;
                        ready_nxt    = 1'b1;
                        index_nxt    = word_cnt;
                        word_cnt_nxt = (word_cnt == 9'd511) ? word_cnt : word_cnt + 9'd1;
                        bit_cnt_nxt  = '0;
                    end else begin
                        bit_cnt_nxt = bit_cnt + BC_W'(1);
                    end
                end
            end
            LOW: begin
                if (sync_p1) begin
                    cnt_nxt   = CNT_ONE;
                    state_nxt = HIGH;
                end else if (cnt == CNT_LAST) begin
                    err_nxt      = (bit_cnt != '0);
                    done_nxt     = (word_cnt != '0);
                    clear_frame  = 1'b1;
                    index_nxt    = '0;
                    word_cnt_nxt = '0;
                    bit_cnt_nxt  = '0;
                    cnt_nxt      = '0;
                    state_nxt    = IDLE;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            default: state_nxt = SYNC;
        endcase
    end

    // Stage p0/p1: two-flop synchronizer; decoder state advances on sync_p1.
    always_ff @(posedge clock) begin
        if (!reset) begin
            sync_p0           <= 1'b0;
            sync_p1           <= 1'b0;
            state             <= SYNC;
            cnt               <= '0;
            bit_cnt           <= '0;
            shreg             <= '0;
            word_cnt          <= '0;
            parallel_data_out <= '0;
            led_index         <= '0;
            data_ready        <= 1'b0;
            frame_done        <= 1'b0;
            bit_error         <= 1'b0;
        end else begin
            sync_p0           <= serial_data_in;
            sync_p1           <= sync_p0;
            state             <= state_nxt;
            cnt               <= cnt_nxt;
            bit_cnt           <= bit_cnt_nxt;
            shreg             <= shreg_nxt;
            word_cnt          <= word_cnt_nxt;
            parallel_data_out <= data_nxt;
            led_index         <= index_nxt;
            data_ready        <= ready_nxt;
            frame_done        <= done_nxt;
            bit_error         <= err_nxt;
        end
    end

`ifdef DECODER_FORWARD_EN
    logic line_p2, fwd_en, fwd_en_nxt;

    always_comb begin
        fwd_en_nxt = fwd_en;
        if (clear_frame)
            fwd_en_nxt = 1'b0;
        else if (ready_nxt)
            fwd_en_nxt = 1'b1;
    end

    // Stage p2 and output register: forwarded line lags sync_p1 by two cycles.
    always_ff @(posedge clock) begin
        if (!reset) begin
            line_p2         <= 1'b0;
            fwd_en          <= 1'b0;
            serial_data_out <= 1'b0;
        end else begin
            line_p2         <= sync_p1;
            fwd_en          <= fwd_en_nxt;
            serial_data_out <= fwd_en ? line_p2 : 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_decoder_xx6812.sv
// Scoreboard bench for decoder_xx6812: stimulus pushes expected events, a monitor pops them.
module tb_decoder_xx6812;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        serial_data_in = 1'b0;
    logic [23:0] parallel_data_out;
    logic        data_ready;
    logic [8:0]  led_index;
    logic        frame_done;
    logic        bit_error;
`ifdef DECODER_FORWARD_EN
    logic        serial_data_out;
`endif

    decoder_xx6812 dut (
        .clock             (clock),
        .reset             (reset),
        .serial_data_in    (serial_data_in),
        .parallel_data_out (parallel_data_out),
        .data_ready        (data_ready),
        .led_index         (led_index),
        .frame_done        (frame_done),
        .bit_error         (bit_error)
`ifdef DECODER_FORWARD_EN
        ,
        .serial_data_out   (serial_data_out)
`endif
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [23:0] data;
        logic [8:0]  idx;
    } word_t;

    word_t exp_words[$];
    int    exp_fd[$];
    int    exp_err[$];
    int    last_ready_cyc = 0;
    word_t mon_w;
    int    mon_d;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every output pulse must match the head of its expectation queue.
    always @(negedge clock) begin
        if (reset) begin
            if (data_ready) begin
                check("data_ready_expected", 64'(exp_words.size() > 0), 64'd1);
                if (exp_words.size() > 0) begin
                    mon_w = exp_words.pop_front();
                    check("word_data", 64'(parallel_data_out), 64'(mon_w.data));
                    check("word_index", 64'(led_index), 64'(mon_w.idx));
                end
                last_ready_cyc = cyc;
            end
            if (frame_done) begin
                check("frame_done_expected", 64'(exp_fd.size() > 0), 64'd1);
                if (exp_fd.size() > 0) begin
                    mon_d = exp_fd.pop_front();
                    if (mon_d >= 0)
                        check("frame_done_delay", 64'(cyc - last_ready_cyc), 64'(mon_d));
                end
            end
            if (bit_error) begin
                check("bit_error_expected", 64'(exp_err.size() > 0), 64'd1);
                if (exp_err.size() > 0)
                    void'(exp_err.pop_front());
            end
        end
    end

`ifdef DECODER_FORWARD_EN
    logic [3:0] hist = '0;
    int fwd_phase = 0;
    int mm0 = 0, mm1 = 0, ones1 = 0;
    always @(negedge clock) begin
        if (fwd_phase == 1 && serial_data_out !== 1'b0) mm0++;
        if (fwd_phase == 2) begin
            if (serial_data_out !== hist[3]) mm1++;
            if (serial_data_out === 1'b1) ones1++;
        end
        hist = {hist[2:0], serial_data_in};
    end
`endif

    task automatic hold(input logic v, input int n);
        serial_data_in = v;
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic send_bits(input logic [23:0] d, input int n);
        for (int i = 0; i < n; i++) begin
            if (d[23-i]) begin
                hold(1'b1, 10);
                hold(1'b0, 5);
            end else begin
                hold(1'b1, 4);
                hold(1'b0, 11);
            end
        end
    endtask

    task automatic send_word(input logic [23:0] d, input logic [8:0] idx);
        exp_words.push_back({d, idx});
        send_bits(d, 24);
    endtask

    task automatic gap_frame();
        exp_fd.push_back(959);
        hold(1'b0, 1000);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_data"}, 64'(parallel_data_out), 64'd0);
        check({tag, "_index"}, 64'(led_index), 64'd0);
        check({tag, "_ready"}, 64'(data_ready), 64'd0);
        check({tag, "_done"}, 64'(frame_done), 64'd0);
        check({tag, "_err"}, 64'(bit_error), 64'd0);
    endtask

    initial begin
        @(posedge clock);
        #1;
        reset = 1'b0;
        hold(1'b0, 4);
        check_zero("reset");
        reset = 1'b1;

        // Single word after power-up gap
        hold(1'b0, 1000);
        send_word(24'hFF0000, 9'd0);
        gap_frame();

        // Three-word frame
        send_word(24'h123456, 9'd0);
        send_word(24'hABCDEF, 9'd1);
        send_word(24'h000001, 9'd2);
        gap_frame();

        // Partial word only: error, no frame_done
        exp_err.push_back(1);
        send_bits(24'hABCDEF, 12);
        hold(1'b0, 1000);

        // Full word then partial: error and frame_done together
        send_word(24'h0F0F0F, 9'd0);
        exp_err.push_back(1);
        exp_fd.push_back(-1);
        send_bits(24'hC3C3C3, 12);
        hold(1'b0, 1000);

        // Runt pulse mid-word, then words ignored until a full gap
        send_bits(24'h555555, 5);
        exp_err.push_back(1);
        hold(1'b1, 1);
        hold(1'b0, 10);
        send_bits(24'h777777, 24);
        hold(1'b0, 1000);
        send_word(24'h00FF00, 9'd0);
        gap_frame();

        // Reset mid-word
        send_word(24'h111111, 9'd0);
        send_word(24'h222222, 9'd1);
        send_bits(24'hFFFFFF, 10);
        serial_data_in = 1'b0;
        reset = 1'b0;
        hold(1'b0, 4);
        check_zero("midreset");
        reset = 1'b1;
        hold(1'b0, 3);
        send_bits(24'h13579B, 24);
        hold(1'b0, 1000);
        send_word(24'h5A5A5A, 9'd0);
        gap_frame();

        // Line stuck high
        exp_err.push_back(1);
        hold(1'b1, 1000);
        hold(1'b0, 1000);
        send_word(24'h800001, 9'd0);
        gap_frame();

`ifdef DECODER_FORWARD_EN
        fwd_phase = 1;
        send_word(24'hA50000, 9'd0);
        fwd_phase = 2;
        send_word(24'h3C3C3C, 9'd1);
        gap_frame();
        fwd_phase = 0;
        check("fwd_word0_quiet", 64'(mm0), 64'd0);
        check("fwd_word1_follow", 64'(mm1), 64'd0);
        check("fwd_word1_active", 64'(ones1 > 0), 64'd1);
`endif

        hold(1'b0, 20);
        check("words_left", 64'(exp_words.size()), 64'd0);
        check("frame_done_left", 64'(exp_fd.size()), 64'd0);
        check("bit_error_left", 64'(exp_err.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
